audio_decimator: RTL

//  Front-end audio conditioning stage that sits directly upstream of the recorder.
//  - Paces the external ADC with a periodic sample-request strobe.
//  - Box-car averages each block of 2^DECIM_LOG2 raw 8-bit samples into one sample.
//  - Applies a power-of-two gain about mid-scale, with saturation.
//  - Delivers 8-bit offset-binary audio plus a one-cycle valid pulse; these drive
//    the recorder's audio_in / audio_valid_in inputs.

---
 rtl/audio_pkg.sv | 34 +++
 rtl/sample_strobe_gen.sv | 44 ++++
 rtl/audio_decimator.sv | 103 ++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared audio constants and the signed 8-bit saturation helper used by both
// the capture (decimator) and playback paths.
//   AUDIO_W    : width of an audio sample
//   AUDIO_MID  : offset-binary mid-scale (silence)
//   sat_s8()   : clamp a 12-bit signed value to [-128, 127] and flag clipping
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int          AUDIO_W   = 8;
    localparam logic [7:0]  AUDIO_MID = 8'h80;

    typedef struct packed {
        logic signed [7:0] value;
        logic              clip;
    } sat_s8_t;

    function automatic sat_s8_t sat_s8(input logic signed [11:0] x);
        sat_s8_t r;
        if (x > 12'sd127) begin
            r.value = 8'sd127;
            r.clip  = 1'b1;
        end else if (x < -12'sd128) begin
            r.value = -8'sd128;
            r.clip  = 1'b1;
        end else begin
            r.value = x[7:0];
            r.clip  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_strobe_gen.sv
// -----------------------------------------------------------------------------
// sample_strobe_gen
// Periodic one-cycle strobe that paces the external ADC. The tick counter runs
// 0..CYCLES_PER_SAMPLE-1 while enabled; the strobe is registered so it appears
// in the cycle after the counter reads its terminal value.
//   clk_in     : system clock
//   rst_in     : asynchronous, active-high reset
//   enable_in  : 1 = count; 0 = hold counter at zero, no strobes
//   strobe_out : one-cycle sample request
// -----------------------------------------------------------------------------
module sample_strobe_gen #(
    parameter int CYCLES_PER_SAMPLE = 7
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic enable_in,
    output logic strobe_out
);

    localparam int TW = (CYCLES_PER_SAMPLE > 2) ? $clog2(CYCLES_PER_SAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CYCLES_PER_SAMPLE - 1);

    logic [TW-1:0] r_tick;
    logic          r_strobe;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tick   <= '0;
            r_strobe <= 1'b0;
        end else if (!enable_in) begin
            r_tick   <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= (r_tick == TICK_LAST);
            r_tick   <= (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
        end
    end

    // A strobe registered just before enable drops is suppressed while idle.
    assign strobe_out = r_strobe & enable_in;

endmodule

// File: rtl/audio_decimator.sv
// -----------------------------------------------------------------------------
// audio_decimator
// Front-end conditioning ahead of the recorder: paces the ADC, box-car averages
// each block of 2^DECIM_LOG2 raw samples, applies a power-of-two gain about
// mid-scale with saturation, and emits registered offset-binary audio.
//   clk_in          : system clock
//   rst_in          : asynchronous, active-high reset
//   enable_in       : 1 = run; 0 = idle, partial block discarded
//   raw_valid_in    : raw_in carries a sample this cycle
//   raw_in          : raw ADC sample, offset-binary
//   gain_in         : left-shift gain 0..3 (x1..x8)
//   sample_req_out  : one-cycle ADC request strobe
//   audio_valid_out : one-cycle pulse, audio_out is new
//   audio_out       : decimated, gained sample, offset-binary (held between pulses)
//   clip_out        : pulses with audio_valid_out when saturation occurred
// -----------------------------------------------------------------------------
module audio_decimator
    import audio_pkg::*;
#(
    parameter int CYCLES_PER_SAMPLE = 7,
    parameter int DECIM_LOG2        = 3
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         enable_in,
    input  logic         raw_valid_in,
    input  logic [7:0]   raw_in,
    input  logic [1:0]   gain_in,
    output logic         sample_req_out,
    output logic         audio_valid_out,
    output logic [7:0]   audio_out,
    output logic         clip_out
);

    localparam int ACC_W = AUDIO_W + DECIM_LOG2;
    // A zero-width counter is illegal, so DECIM_LOG2=0 keeps one bit that stays 0.
    localparam int CW    = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << DECIM_LOG2) - 1);

    logic [ACC_W-1:0]   r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_valid;
    logic               r_clip;
    logic [7:0]         r_audio;

    logic [ACC_W-1:0]   w_sum;
    logic [7:0]         w_mean;
    logic signed [8:0]  w_centred;
    logic signed [11:0] w_gained;
    sat_s8_t            w_sat;

    sample_strobe_gen #(
        .CYCLES_PER_SAMPLE (CYCLES_PER_SAMPLE)
    ) u_strobe (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .enable_in  (enable_in),
        .strobe_out (sample_req_out)
    );

    // Datapath for the sample that completes a block. The sum of 2^DECIM_LOG2
    // 8-bit samples always fits ACC_W bits, so no carry is lost.
    assign w_sum     = r_acc + ACC_W'(raw_in);
    assign w_mean    = 8'(w_sum >> DECIM_LOG2);
    assign w_centred = $signed({1'b0, w_mean} - 9'd128);
    // |centred| <= 128, so x8 still fits 12-bit signed.
    assign w_gained  = $signed({{3{w_centred[8]}}, w_centred}) <<< gain_in;
    assign w_sat     = sat_s8(w_gained);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_clip  <= 1'b0;
            r_audio <= AUDIO_MID;
        end else begin
            r_valid <= 1'b0;
            r_clip  <= 1'b0;
            if (!enable_in) begin
                // Idle drops any partial block, including one completing now.
                r_acc <= '0;
                r_cnt <= '0;
            end else if (raw_valid_in) begin
                if (r_cnt == CNT_LAST) begin
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_valid <= 1'b1;
                    r_clip  <= w_sat.clip;
                    r_audio <= 8'(w_sat.value) + AUDIO_MID;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign audio_valid_out = r_valid;
    assign clip_out        = r_clip;
    assign audio_out       = r_audio;

endmodule
